// File: rtl/pu_msp430_div.sv
// pu_msp430_div: iterative restoring divider, 16/16 word or 8/8 byte mode.
// One quotient bit is resolved per clock. Results are returned with a
// one-cycle done pulse and ALU-style status {V,N,Z,C}.
module pu_msp430_div #(
   parameter int DW = 16
) (
   input  logic          mclk,
   input  logic          puc_rst,
   input  logic          start,
   input  logic          op_signed,
   input  logic          inst_bw,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic [3:0]    div_stat,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Two's-complement negate over the active width; the upper byte is
   // forced to zero in byte mode.
   function automatic logic [DW-1:0] neg_act(input logic [DW-1:0] x, input logic bw);
      logic [DW-1:0] n;
      n = (~x) + {{(DW-1){1'b0}}, 1'b1};
      return bw ? {{(DW-8){1'b0}}, n[7:0]} : n;
   endfunction

   state_t        state_r;
   logic [DW-1:0] dvd_r;
   logic [DW-1:0] dvs_r;
   logic          sgn_r;
   logic          bw_r;
   logic [DW-1:0] dvs_mag_r;
   logic [DW-1:0] rem_r;
   logic [DW-1:0] quo_r;
   logic [4:0]    cnt_r;

   logic [DW-1:0] dvd_act_s;
   logic [DW-1:0] dvs_act_s;
   logic          dvd_neg_s;
   logic          dvs_neg_s;
   logic [DW-1:0] dvd_mag_s;
   logic [DW-1:0] dvs_mag_s;
   logic [DW:0]   shift_s;
   logic          borrow_s;
   logic [DW-1:0] trial_s;
   logic [DW-1:0] rem_next_s;
   logic [DW-1:0] q_raw_s;
   logic [DW-1:0] q_fix_s;
   logic [DW-1:0] r_fix_s;
   logic          ovf_s;
   logic          q_msb_s;
   logic [3:0]    stat_fix_s;

   // Operand conditioning, one restoring step and the sign fix-up result.
   always_comb begin
      dvd_act_s  = bw_r ? {{(DW-8){1'b0}}, dvd_r[7:0]} : dvd_r;
      dvs_act_s  = bw_r ? {{(DW-8){1'b0}}, dvs_r[7:0]} : dvs_r;
      dvd_neg_s  = sgn_r & (bw_r ? dvd_r[7] : dvd_r[DW-1]);
      dvs_neg_s  = sgn_r & (bw_r ? dvs_r[7] : dvs_r[DW-1]);
      dvd_mag_s  = dvd_neg_s ? neg_act(dvd_act_s, bw_r) : dvd_act_s;
      dvs_mag_s  = dvs_neg_s ? neg_act(dvs_act_s, bw_r) : dvs_act_s;

      // The partial remainder always stays below the divisor, so the
      // shifted value needs one extra bit and the difference fits DW bits.
      shift_s    = {rem_r, quo_r[DW-1]};
      borrow_s   = (shift_s < {1'b0, dvs_mag_r});
      trial_s    = shift_s[DW-1:0] - dvs_mag_r;
      rem_next_s = borrow_s ? shift_s[DW-1:0] : trial_s;

      q_raw_s    = bw_r ? {{(DW-8){1'b0}}, quo_r[7:0]} : quo_r;
      q_fix_s    = (dvd_neg_s ^ dvs_neg_s) ? neg_act(q_raw_s, bw_r) : q_raw_s;
      r_fix_s    = dvd_neg_s ? neg_act(rem_r, bw_r) : rem_r;

      ovf_s      = sgn_r
                 & (dvd_act_s == (bw_r ? 16'h0080 : 16'h8000))
                 & (dvs_act_s == (bw_r ? 16'h00FF : 16'hFFFF));
      q_msb_s    = bw_r ? q_fix_s[7] : q_fix_s[DW-1];
      stat_fix_s = {ovf_s, q_msb_s, (q_fix_s == {DW{1'b0}}), (r_fix_s != {DW{1'b0}})};
   end

   // Control FSM with registered results, status, busy and done.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state_r   <= S_IDLE;
         dvd_r     <= {DW{1'b0}};
         dvs_r     <= {DW{1'b0}};
         sgn_r     <= 1'b0;
         bw_r      <= 1'b0;
         dvs_mag_r <= {DW{1'b0}};
         rem_r     <= {DW{1'b0}};
         quo_r     <= {DW{1'b0}};
         cnt_r     <= 5'd0;
         quotient  <= {DW{1'b0}};
         remainder <= {DW{1'b0}};
         div_stat  <= 4'b0000;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  dvd_r   <= dividend;
                  dvs_r   <= divisor;
                  sgn_r   <= op_signed;
                  bw_r    <= inst_bw;
                  busy    <= 1'b1;
                  state_r <= S_PREP;
               end else begin
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_PREP: begin
               if (dvs_mag_s == {DW{1'b0}}) begin
                  quotient  <= bw_r ? 16'h00FF : 16'hFFFF;
                  remainder <= dvd_act_s;
                  div_stat  <= 4'b1101;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= S_DONE;
               end else begin
                  rem_r     <= {DW{1'b0}};
                  // Byte operands sit in the top byte so that the quotient
                  // bits shifted in land in the low byte after 8 steps.
                  quo_r     <= bw_r ? {dvd_mag_s[7:0], {(DW-8){1'b0}}} : dvd_mag_s;
                  dvs_mag_r <= dvs_mag_s;
                  cnt_r     <= bw_r ? 5'd8 : 5'd16;
                  state_r   <= S_RUN;
               end
            end
            S_RUN: begin
               rem_r <= rem_next_s;
               quo_r <= {quo_r[DW-2:0], ~borrow_s};
               cnt_r <= cnt_r - 5'd1;
               if (cnt_r == 5'd1) begin
                  state_r <= S_FIX;
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_FIX: begin
               quotient  <= q_fix_s;
               remainder <= r_fix_s;
               div_stat  <= stat_fix_s;
               busy      <= 1'b0;
               done      <= 1'b1;
               state_r   <= S_DONE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pu_msp430_div.sv
// tb_pu_msp430_div: directed and random checks of pu_msp430_div against an
// arithmetic reference model (integer division truncating toward zero).
module tb_pu_msp430_div;

   logic        mclk;
   logic        puc_rst;
   logic        start;
   logic        op_signed;
   logic        inst_bw;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic [3:0]  div_stat;
   logic        busy;
   logic        done;

   int tests;
   int fails;

   logic [15:0] exp_q;
   logic [15:0] exp_r;
   logic [3:0]  exp_st;
   int          exp_lat;

   pu_msp430_div #(.DW(16)) dut (
      .mclk      (mclk),
      .puc_rst   (puc_rst),
      .start     (start),
      .op_signed (op_signed),
      .inst_bw   (inst_bw),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .div_stat  (div_stat),
      .busy      (busy),
      .done      (done)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division over the active width.
   function automatic void model(input logic sgn, input logic bw,
                                 input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic [3:0] st);
      longint mask, half, av, bv, sa, sb, qi, ri;
      logic   v;
      mask = bw ? 64'd255 : 64'd65535;
      half = (mask + 1) / 2;
      av = longint'(a) & mask;
      bv = longint'(b) & mask;
      v  = 1'b0;
      if (bv == 0) begin
         q  = mask[15:0];
         r  = av[15:0];
         st = 4'b1101;
      end else begin
         if (sgn) begin
            sa = (av >= half) ? av - (mask + 1) : av;
            sb = (bv >= half) ? bv - (mask + 1) : bv;
            if (sa == -half && sb == -1) begin
               v  = 1'b1;
               qi = half;
               ri = 0;
            end else begin
               qi = sa / sb;
               ri = sa % sb;
            end
         end else begin
            qi = av / bv;
            ri = av % bv;
         end
         qi = qi & mask;
         ri = ri & mask;
         q  = qi[15:0];
         r  = ri[15:0];
         st = {v, (bw ? qi[7] : qi[15]), (qi == 0), (ri != 0)};
      end
   endfunction

   // Drive a request in the current cycle and compute its expected outcome.
   task automatic launch(input logic sgn, input logic bw, input logic [15:0] a, input logic [15:0] b);
      op_signed = sgn;
      inst_bw   = bw;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      model(sgn, bw, a, b, exp_q, exp_r, exp_st);
      exp_lat = ((bw ? (b & 16'h00FF) : b) == 16'h0000) ? 2 : (bw ? 11 : 19);
   endtask

   // Follow the operation to its done pulse and compare everything.
   task automatic wait_check(input string tag, input int glitch_cyc);
      int   cyc;
      logic busy_bad;
      @(posedge mclk); #1;
      start    = 1'b0;
      cyc      = 1;
      busy_bad = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         start = (cyc == glitch_cyc);
         if (cyc == glitch_cyc) begin
            dividend = 16'h00FF;
            divisor  = 16'h0001;
         end
         @(posedge mclk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_lat"},  cyc, exp_lat);
      chk({tag, "_busy"}, {busy_bad, busy}, 2'b00);
      chk({tag, "_q"},    quotient, exp_q);
      chk({tag, "_r"},    remainder, exp_r);
      chk({tag, "_st"},   div_stat, exp_st);
   endtask

   task automatic do_op(input string tag, input logic sgn, input logic bw,
                        input logic [15:0] a, input logic [15:0] b);
      @(posedge mclk); #1;
      launch(sgn, bw, a, b);
      wait_check(tag, 0);
   endtask

   initial begin
      int   saw_done;
      logic sgn, bw;
      logic [15:0] a, b;
      int   sel;
      tests     = 0;
      fails     = 0;
      puc_rst   = 1'b1;
      start     = 1'b0;
      op_signed = 1'b0;
      inst_bw   = 1'b0;
      dividend  = 16'h0000;
      divisor   = 16'h0000;
      repeat (2) @(posedge mclk);
      #1;
      chk("rst_outs", {quotient, remainder}, 32'h0000_0000);
      chk("rst_ctl",  {div_stat, busy, done}, 6'b000000);
      puc_rst = 1'b0;

      do_op("u_word",   1'b0, 1'b0, 16'h0064, 16'h0007);
      do_op("s_word",   1'b1, 1'b0, 16'hFF9C, 16'h0007);
      do_op("div0",     1'b0, 1'b0, 16'h04D2, 16'h0000);
      do_op("u_byte",   1'b0, 1'b1, 16'h1234, 16'hAB05);
      do_op("s_ovf",    1'b1, 1'b0, 16'h8000, 16'hFFFF);
      do_op("s_ovf_b",  1'b1, 1'b1, 16'h1280, 16'h34FF);
      do_op("div0_b",   1'b1, 1'b1, 16'h12F3, 16'h5600);
      do_op("s_negdvs", 1'b1, 1'b0, 16'h0064, 16'hFFF9);
      do_op("u_big",    1'b0, 1'b0, 16'hFFFF, 16'hFFFE);

      // Restart pulse in cycle 5 must be ignored.
      @(posedge mclk); #1;
      launch(1'b0, 1'b0, 16'h0064, 16'h0007);
      wait_check("restart_ign", 5);

      // Back-to-back: start during the DONE cycle.
      launch(1'b1, 1'b0, 16'h7FFF, 16'h0003);
      wait_check("b2b", 0);

      // Reset in cycle 8 aborts with no done pulse.
      @(posedge mclk); #1;
      launch(1'b0, 1'b0, 16'h0064, 16'h0007);
      @(posedge mclk); #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge mclk); #1;
      end
      puc_rst = 1'b1;
      @(posedge mclk); #1;
      puc_rst = 1'b0;
      chk("abort_outs", {quotient, remainder}, 32'h0000_0000);
      chk("abort_ctl",  {div_stat, busy, done}, 6'b000000);
      saw_done = 0;
      repeat (30) begin
         @(posedge mclk); #1;
         if (done === 1'b1) saw_done++;
      end
      chk("abort_nodone", saw_done, 0);

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         bw  = 1'($urandom_range(0, 1));
         a   = 16'($urandom);
         sel = $urandom_range(0, 9);
         case (sel)
            0:       b = 16'($urandom) & 16'hFF00;
            1:       b = 16'hFFFF;
            2, 3:    b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         if (sel == 1 && $urandom_range(0, 1) == 1) a = bw ? 16'h0080 : 16'h8000;
         do_op("rand", sgn, bw, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pu_msp430_div.md
Name: pu_msp430_div

Overview:
- Iterative 16/8-bit hardware divider, the sequential inverse of the CPU's combinational add/multiply datapath.
- Used by software-driven arithmetic and by the peripheral-mapped math unit.
- Inputs are accepted on a start pulse; one quotient bit is resolved per clock with a restoring algorithm.
- Results are returned with a done pulse and ALU-style status {V,N,Z,C}.

Parameters:
- DW, 16, maximum operand width in bits. Byte mode always uses 8; only 16 is supported for integration.

Ports:
- mclk  input  1  core clock; all logic is on its rising edge.
- puc_rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op_signed  input  1  1 = two's-complement division, 0 = unsigned.
- inst_bw  input  1  1 = byte mode, using dividend[7:0] and divisor[7:0].
- dividend  input  16  numerator; captured on the accepted start.
- divisor  input  16  denominator; captured on the accepted start.
- quotient  output  16  result quotient; registered, held until the next accepted start.
- remainder  output  16  result remainder; registered, held until the next accepted start.
- div_stat  output  4  status {V,N,Z,C}; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid in the same cycle.

Behaviour:
- Reset: puc_rst=1 at a clock edge forces the following, regardless of state (including mid-operation):
  - state=IDLE.
  - quotient=0, remainder=0, div_stat=0.
  - busy=0, done=0; no done pulse is issued for the aborted operation.
- N = 8 if inst_bw is captured as 1, else 16.
- States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
- IDLE/DONE: start=1 captures all operands and mode, and enters PREP. start in any other state is ignored, with no queuing.
- PREP (1 cycle):
  - Compute operand magnitudes: abs() when op_signed=1, using bit N-1 as sign.
  - Byte mode: upper input bytes are ignored.
  - Divisor magnitude = 0 -> go directly to DONE with the divide-by-zero result.
  - Otherwise clear the partial remainder, load the counter with N, and go to RUN.
- RUN (exactly N cycles):
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor, computed N+1 bits wide.
  - If there is no borrow: rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - Decrement the counter; at 0 go to FIX.
- FIX (1 cycle):
  - Negate the quotient if the sign of the dividend differs from the sign of the divisor (signed mode only).
  - Negate the remainder if the dividend is negative, giving truncation toward zero.
  - Register the results and status, then go to DONE.
- DONE (1 cycle): done=1, busy=0.
- Timing:
  - start in cycle 0 -> busy=1 in cycles 1..N+2 -> done=1 in cycle N+3. Word: cycle 19; byte: cycle 11.
  - Divide-by-zero: busy=1 in cycle 1, done=1 in cycle 2.
  - Back-to-back: start asserted during DONE enters PREP the next cycle, so there is no idle bubble.
- Byte mode: quotient[15:8]=0 and remainder[15:8]=0. Flags use bit 7 and the low byte.
- Divide-by-zero result:
  - quotient = all ones (0xFFFF, or 0x00FF in byte mode).
  - remainder = the captured dividend, low byte only in byte mode.
  - div_stat = {1,1,0,1}.
- Status in normal completion:
  - V = signed overflow: dividend = most-negative and divisor = -1. In that case quotient = most-negative (0x8000 / 0x0080) and remainder = 0. V=0 otherwise.
  - N = quotient MSB (bit 15, or bit 7 in byte mode).
  - Z = quotient==0 over the active width.
  - C = remainder!=0.
- Unsigned mode never sets V except on divide-by-zero.
- Outputs change only at the FIX->DONE transition or the PREP->DONE (divide-by-zero) transition, and on reset.

Test Plan:
- Unsigned word 100/7 (0x0064/0x0007):
  - done in cycle 19, quotient=0x000E, remainder=0x0002, div_stat=4'b0001.
  - busy high in cycles 1..18.
- Signed word -100/7 (0xFF9C/0x0007): quotient=0xFFF2, remainder=0xFFFE, div_stat=4'b0101.
- Divide-by-zero 0x04D2/0x0000, unsigned word: done in cycle 2, quotient=0xFFFF, remainder=0x04D2, div_stat=4'b1101.
- Byte mode unsigned 0x1234/0xAB05:
  - operands used are 0x34/0x05.
  - done in cycle 11, quotient=0x000A, remainder=0x0002, div_stat=4'b0001.
- Signed overflow 0x8000/0xFFFF: quotient=0x8000, remainder=0x0000, div_stat=4'b1100.
- Control cases:
  - start re-pulsed in cycle 5 of a word operation is ignored; the original result arrives in cycle 19.
  - puc_rst in cycle 8 gives IDLE, all outputs 0, and no done pulse.
  - start asserted in the DONE cycle gives the next done exactly 19 cycles later.
